output_writer: RTL

OUTPUT_WRITER -- requirements
Module: output_writer

---
 rtl/output_writer.sv | 122 ++++++++++++
 1 files changed

// File: rtl/output_writer.sv
// output_writer: gathers a stream of DATA_WIDTH elements into DATA_LENGTH-wide
// SRAM lines and writes i_addr_offset consecutive lines starting at i_addr.
// The write strobe, address, data, busy and done outputs are registered and
// produced by the WRITE / DONE states, so they appear one cycle after the
// state is entered. Ready is decoded directly from the state.
module output_writer #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 8,
    parameter int DATA_LENGTH = 8
) (
    input  logic                                   i_clk,
    input  logic                                   i_nrst,
    input  logic                                   i_reg_clear,
    input  logic                                   i_start,
    input  logic [ADDR_WIDTH-1:0]                  i_addr,
    input  logic [ADDR_WIDTH-1:0]                  i_addr_offset,
    input  logic                                   i_data_valid,
    input  logic [DATA_WIDTH-1:0]                  i_data,
    output logic                                   o_data_ready,
    output logic                                   o_sram_write_en,
    output logic [ADDR_WIDTH-1:0]                  o_write_addr,
    output logic [DATA_LENGTH-1:0][DATA_WIDTH-1:0] o_write_data,
    output logic                                   o_busy,
    output logic                                   o_done
);

    localparam int LANE_W = $clog2(DATA_LENGTH);

    typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

    state_t                                state, state_nxt;
    logic [LANE_W-1:0]                     lane_cnt;
    logic [ADDR_WIDTH-1:0]                 line_cnt;
    logic [ADDR_WIDTH-1:0]                 base;
    logic [ADDR_WIDTH-1:0]                 count;
    logic [DATA_LENGTH-1:0][DATA_WIDTH-1:0] line_buf;
    logic                                  accept;
    logic                                  last_lane;
    logic                                  last_line;

    assign o_data_ready = (state == COLLECT);
    assign accept       = (state == COLLECT) && i_data_valid;
    assign last_lane    = (lane_cnt == LANE_W'(DATA_LENGTH - 1));
    // count never exceeds 2^ADDR_WIDTH-1, so line_cnt+1 cannot wrap before matching
    assign last_line    = ((line_cnt + ADDR_WIDTH'(1)) == count);

    // State register; clear has priority over normal sequencing
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst)          state <= IDLE;
        else if (i_reg_clear) state <= IDLE;
        else                  state <= state_nxt;
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_start) state_nxt = (i_addr_offset != '0) ? COLLECT : DONE;
            COLLECT: if (accept && last_lane) state_nxt = WRITE;
            WRITE:   state_nxt = last_line ? DONE : COLLECT;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Job registers, line buffer and registered outputs
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            lane_cnt        <= '0;
            line_cnt        <= '0;
            base            <= '0;
            count           <= '0;
            line_buf        <= '0;
            o_sram_write_en <= 1'b0;
            o_write_addr    <= '0;
            o_write_data    <= '0;
            o_busy          <= 1'b0;
            o_done          <= 1'b0;
        end else if (i_reg_clear) begin
            lane_cnt        <= '0;
            line_cnt        <= '0;
            base            <= '0;
            count           <= '0;
            line_buf        <= '0;
            o_sram_write_en <= 1'b0;
            o_write_addr    <= '0;
            o_write_data    <= '0;
            o_busy          <= 1'b0;
            o_done          <= 1'b0;
        end else begin
            o_sram_write_en <= 1'b0;
            o_write_addr    <= '0;
            o_write_data    <= '0;
            o_busy          <= (state != IDLE);
            o_done          <= (state == DONE);
            case (state)
                IDLE: begin
                    if (i_start && (i_addr_offset != '0)) begin
                        base     <= i_addr;
                        count    <= i_addr_offset;
                        lane_cnt <= '0;
                        line_cnt <= '0;
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        line_buf[lane_cnt] <= i_data;
                        lane_cnt           <= lane_cnt + LANE_W'(1);
                    end
                end
                WRITE: begin
                    o_sram_write_en <= 1'b1;
                    o_write_addr    <= base + line_cnt;
                    o_write_data    <= line_buf;
                    line_cnt        <= line_cnt + ADDR_WIDTH'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
